// File: rtl/instr_decode_if.sv
// Decoder bus: instruction word in, registered control signals and split fields out.
// The decoder is the slave; whoever fetches instructions is the master.
interface instr_decode_if;
    logic [31:0] IR;
    logic        ir_valid;
    logic        valid_out;
    logic        RegDst;
    logic        ALUSrc;
    logic        MemtoReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        ALUOp1;
    logic        ALUOp0;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [4:0]  write_reg;
    logic        illegal;

    modport master (
        output IR, ir_valid,
        input  valid_out, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, ALUOp1, ALUOp0, opcode, rs, rt, rd, shamt, funct,
               imm_sext, write_reg, illegal
    );

    modport slave (
        input  IR, ir_valid,
        output valid_out, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, ALUOp1, ALUOp0, opcode, rs, rt, rd, shamt, funct,
               imm_sext, write_reg, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// Registered MIPS main decoder: one-cycle latency from IR to control signals,
// split instruction fields, sign-extended immediate and destination register.
module instr_decode (
    input  logic           clk,
    input  logic           reset,
    instr_decode_if.slave  bus
);

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_op1;
        logic alu_op0;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    ctrl_t       ctrl_next;
    ctrl_t       ctrl_reg;
    logic        illegal_next;
    logic        illegal_reg;
    logic        valid_reg;
    logic [31:0] imm_next;
    logic [31:0] imm_reg;
    logic [4:0]  write_reg_next;
    logic [4:0]  write_reg_reg;
    logic [31:0] ir_reg;

    // Control decode looks only at the opcode; funct and shamt never affect it.
    always_comb begin
        ctrl_next    = '0;
        illegal_next = 1'b0;
        case (bus.IR[31:26])
            OP_RTYPE: ctrl_next = 9'b1_0_0_1_0_0_0_1_0;
            OP_LW:    ctrl_next = 9'b0_1_1_1_1_0_0_0_0;
            OP_SW:    ctrl_next = 9'b0_1_0_0_0_1_0_0_0;
            OP_BEQ:   ctrl_next = 9'b0_0_0_0_0_0_1_0_1;
            default:  illegal_next = 1'b1;
        endcase
    end

    always_comb begin
        write_reg_next = ctrl_next.reg_dst ? bus.IR[15:11] : bus.IR[20:16];
    end

    assign imm_next[15:0] = bus.IR[15:0];
    generate
        for (genvar gi = 16; gi < 32; gi++) begin : g_sext
            assign imm_next[gi] = bus.IR[15];
        end
    endgenerate

    // Idle cycles clear controls but keep the last accepted fields visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg      <= '0;
            illegal_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            imm_reg       <= '0;
            write_reg_reg <= '0;
            ir_reg        <= '0;
        end else begin
            valid_reg <= bus.ir_valid;
            if (bus.ir_valid) begin
                ctrl_reg      <= ctrl_next;
                illegal_reg   <= illegal_next;
                imm_reg       <= imm_next;
                write_reg_reg <= write_reg_next;
                ir_reg        <= bus.IR;
            end else begin
                ctrl_reg    <= '0;
                illegal_reg <= 1'b0;
            end
        end
    end

    assign bus.valid_out = valid_reg;
    assign bus.RegDst    = ctrl_reg.reg_dst;
    assign bus.ALUSrc    = ctrl_reg.alu_src;
    assign bus.MemtoReg  = ctrl_reg.mem_to_reg;
    assign bus.RegWrite  = ctrl_reg.reg_write;
    assign bus.MemRead   = ctrl_reg.mem_read;
    assign bus.MemWrite  = ctrl_reg.mem_write;
    assign bus.Branch    = ctrl_reg.branch;
    assign bus.ALUOp1    = ctrl_reg.alu_op1;
    assign bus.ALUOp0    = ctrl_reg.alu_op0;
    assign bus.illegal   = illegal_reg;

    assign bus.opcode    = ir_reg[31:26];
    assign bus.rs        = ir_reg[25:21];
    assign bus.rt        = ir_reg[20:16];
    assign bus.rd        = ir_reg[15:11];
    assign bus.shamt     = ir_reg[10:6];
    assign bus.funct     = ir_reg[5:0];
    assign bus.imm_sext  = imm_reg;
    assign bus.write_reg = write_reg_reg;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: each step drives one cycle of input, pushes the
// modelled output onto a scoreboard, and compares it after the next rising edge.
module tb_instr_decode;

    logic clk;
    logic reset;
    instr_decode_if bus ();

    instr_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic        valid;
        logic        illegal;
        logic [31:0] fields;
        logic [31:0] imm;
        logic [4:0]  wr;
    } exp_t;

    exp_t model_state;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b100100010;
            6'h23:   return 9'b011110000;
            6'h2B:   return 9'b010001000;
            6'h04:   return 9'b000000101;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic exp_t model(input exp_t prev, input logic [31:0] ir,
                                   input logic v, input logic r);
        exp_t e;
        e = prev;
        if (r) begin
            e = '0;
        end else if (!v) begin
            e.ctrl    = '0;
            e.valid   = 1'b0;
            e.illegal = 1'b0;
        end else begin
            e.ctrl    = ctrl_of(ir[31:26]);
            e.valid   = 1'b1;
            e.illegal = !(ir[31:26] inside {6'h00, 6'h23, 6'h2B, 6'h04});
            e.fields  = ir;
            e.imm     = {{16{ir[15]}}, ir[15:0]};
            e.wr      = e.ctrl[8] ? ir[15:11] : ir[20:16];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        logic [8:0] ctrl_obs;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        ctrl_obs = {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                    bus.MemWrite, bus.Branch, bus.ALUOp1, bus.ALUOp0};
        chk({tag, "_ctrl"},      {23'd0, ctrl_obs}, {23'd0, e.ctrl});
        chk({tag, "_valid"},     {31'd0, bus.valid_out}, {31'd0, e.valid});
        chk({tag, "_illegal"},   {31'd0, bus.illegal}, {31'd0, e.illegal});
        chk({tag, "_fields"},    {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, e.fields);
        chk({tag, "_imm"},       bus.imm_sext, e.imm);
        chk({tag, "_write_reg"}, {27'd0, bus.write_reg}, {27'd0, e.wr});
        $display("txn %-10s ctrl=%b valid=%b illegal=%b rs=%0d rt=%0d rd=%0d imm=%h wr=%0d",
                 tag, ctrl_obs, bus.valid_out, bus.illegal, bus.rs, bus.rt, bus.rd,
                 bus.imm_sext, bus.write_reg);
    endtask

    task automatic step(input string tag, input logic [31:0] ir, input logic v, input logic r);
        bus.IR       = ir;
        bus.ir_valid = v;
        reset        = r;
        model_state  = model(model_state, ir, v, r);
        sb.push_back(model_state);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        logic [31:0] rir;
        logic [5:0]  ops [5];
        model_state  = '0;
        bus.IR       = '0;
        bus.ir_valid = 1'b0;
        reset        = 1'b1;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;

        step("reset0",  32'h0000_0000, 1'b0, 1'b1);
        step("reset1",  32'h0000_0000, 1'b1, 1'b1);
        step("rtype",   32'h0210_8420, 1'b1, 1'b0);
        step("lw",      32'h8C48_0004, 1'b1, 1'b0);
        step("sw",      32'hAC48_0008, 1'b1, 1'b0);
        step("beq",     32'h1109_FFFF, 1'b1, 1'b0);
        step("illegal", 32'h0800_0000, 1'b1, 1'b0);
        step("lw2",     32'h8C48_0004, 1'b1, 1'b0);
        step("idle",    32'hFFFF_FFFF, 1'b0, 1'b0);
        // Explicit hold check on the lw fields after the idle cycle.
        chk("hold_rs",  {27'd0, bus.rs}, 32'd2);
        chk("hold_rt",  {27'd0, bus.rt}, 32'd8);
        chk("hold_imm", bus.imm_sext, 32'h0000_0004);
        step("rt_rst",  32'h0210_8420, 1'b1, 1'b1);
        step("after",   32'h0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rir = $urandom;
            rir[31:26] = ops[$urandom_range(0, 4)];
            step($sformatf("rand%0d", i), rir, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
